// File: rtl/ctrl_pkg.sv
// Shared definitions for the control pipeline: the control word layout, ALU op codes
// and PC select codes.
package ctrl_pkg;

  localparam int CTRL_W = 13;

  localparam int ALU_OP_HI    = 12;
  localparam int ALU_OP_LO    = 10;
  localparam int BIT_USE_IMM  = 9;
  localparam int BIT_MEM_RD   = 8;
  localparam int BIT_MEM_WR   = 7;
  localparam int BIT_REG_WR   = 6;
  localparam int BIT_MEM2REG  = 5;
  localparam int BIT_PC2REG   = 4;
  localparam int BIT_BRZ      = 3;
  localparam int BIT_BRN      = 2;
  localparam int BIT_JUMP     = 1;
  localparam int BIT_JUMP_MEM = 0;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_INC  = 3'b001,
    ALU_NOP  = 3'b010,
    ALU_SUB  = 3'b101,
    ALU_NEG  = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SEL_SEQ = 2'b00,
    PC_SEL_EX  = 2'b01,
    PC_SEL_MEM = 2'b10
  } pc_sel_e;

  localparam logic [CTRL_W-1:0] CTRL_NOP = {ALU_NOP, 10'b0};

  // Only plain ALU results that go to the register file set the flags.
  function automatic logic writes_flags(input logic [CTRL_W-1:0] ctrl);
    return ctrl[BIT_REG_WR] && !ctrl[BIT_MEM2REG] && !ctrl[BIT_PC2REG] &&
           (ctrl[ALU_OP_HI:ALU_OP_LO] != ALU_NOP);
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register holding {valid, ctrl}; a bubble or an invalid input
// loads an all-zero, invalid entry.
module ctrl_stage_reg
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl
);

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (bubble || !valid_in) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else begin
      valid <= 1'b1;
      ctrl  <= ctrl_in;
    end
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries the decoded control word through EX, MEM and WB, resolves branches/jumps,
// holds the Z/N flags and counts retired instructions.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_valid,
  input  logic              stall,
  input  logic              alu_z,
  input  logic              alu_n,
  output logic [2:0]        ex_alu_op,
  output logic              ex_use_imm,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              wb_pc_to_reg,
  output logic [1:0]        pc_sel,
  output logic              flush_ifid,
  output logic              flag_z,
  output logic              flag_n,
  output logic [CNT_W-1:0]  retired
);

  logic              ex_valid, mem_valid, wb_valid;
  logic [CTRL_W-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [CTRL_W-1:0] id_word;
  logic              ex_taken, mem_jm;

  // An all-zero word from decode is an undecoded opcode; it travels as a plain NOP.
  assign id_word = (id_ctrl == '0) ? CTRL_NOP : id_ctrl;

  assign ex_taken = ex_valid && (ex_ctrl[BIT_JUMP] ||
                                 (ex_ctrl[BIT_BRZ] && flag_z) ||
                                 (ex_ctrl[BIT_BRN] && flag_n));
  assign mem_jm   = mem_valid && mem_ctrl[BIT_JUMP_MEM];

  ctrl_stage_reg u_ex (
    .clk      (clk),
    .rst      (rst),
    .bubble   (stall || ex_taken || mem_jm),
    .valid_in (id_valid),
    .ctrl_in  (id_word),
    .valid    (ex_valid),
    .ctrl     (ex_ctrl)
  );

  ctrl_stage_reg u_mem (
    .clk      (clk),
    .rst      (rst),
    .bubble   (mem_jm),
    .valid_in (ex_valid),
    .ctrl_in  (ex_ctrl),
    .valid    (mem_valid),
    .ctrl     (mem_ctrl)
  );

  ctrl_stage_reg u_wb (
    .clk      (clk),
    .rst      (rst),
    .bubble   (1'b0),
    .valid_in (mem_valid),
    .ctrl_in  (mem_ctrl),
    .valid    (wb_valid),
    .ctrl     (wb_ctrl)
  );

  // An EX instruction killed by a JM in MEM must not touch the flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (ex_valid && !mem_jm && writes_flags(ex_ctrl)) begin
      flag_z <= alu_z;
      flag_n <= alu_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired <= '0;
    else if (wb_valid) retired <= retired + 1'b1;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    ex_alu_op     = ALU_NOP;
    ex_use_imm    = 1'b0;
    mem_read      = mem_valid && mem_ctrl[BIT_MEM_RD];
    mem_write     = mem_valid && mem_ctrl[BIT_MEM_WR];
    wb_reg_write  = wb_valid && wb_ctrl[BIT_REG_WR];
    wb_mem_to_reg = wb_valid && wb_ctrl[BIT_MEM2REG];
    wb_pc_to_reg  = wb_valid && wb_ctrl[BIT_PC2REG];
    pc_sel        = PC_SEL_SEQ;
    flush_ifid    = 1'b0;
    if (ex_valid) begin
      ex_alu_op  = ex_ctrl[ALU_OP_HI:ALU_OP_LO];
      ex_use_imm = ex_ctrl[BIT_USE_IMM];
    end
    if (mem_jm) begin
      pc_sel     = PC_SEL_MEM;
      flush_ifid = 1'b1;
    end else if (ex_taken) begin
      pc_sel     = PC_SEL_EX;
      flush_ifid = 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed test of ctrl_pipeline: reset, latency, branches, stall and JM priority.
module tb_ctrl_pipeline;

  // Control words: [12:10]ALUOp [9]imm [8]MR [7]MW [6]RW [5]M2R [4]P2R [3]BZ [2]BN [1]J [0]JM
  localparam logic [12:0] W_ADD = 13'h0040; // ADD, RegWrite
  localparam logic [12:0] W_NOP = 13'h0800; // ALUOp 010
  localparam logic [12:0] W_SUB = 13'h1440; // SUB, RegWrite
  localparam logic [12:0] W_BRZ = 13'h0808;
  localparam logic [12:0] W_BRN = 13'h0804;
  localparam logic [12:0] W_LD  = 13'h0360; // ADD, imm, MemRead, RegWrite, MemToReg
  localparam logic [12:0] W_J   = 13'h0802;
  localparam logic [12:0] W_JM  = 13'h0801;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] id_ctrl;
  logic        id_valid, stall, alu_z, alu_n;
  logic [2:0]  ex_alu_op;
  logic        ex_use_imm, mem_read, mem_write;
  logic        wb_reg_write, wb_mem_to_reg, wb_pc_to_reg;
  logic [1:0]  pc_sel;
  logic        flush_ifid, flag_z, flag_n;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  ctrl_pipeline #(.CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_ctrl       (id_ctrl),
    .id_valid      (id_valid),
    .stall         (stall),
    .alu_z         (alu_z),
    .alu_n         (alu_n),
    .ex_alu_op     (ex_alu_op),
    .ex_use_imm    (ex_use_imm),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_pc_to_reg  (wb_pc_to_reg),
    .pc_sel        (pc_sel),
    .flush_ifid    (flush_ifid),
    .flag_z        (flag_z),
    .flag_n        (flag_n),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    id_valid = 1'b0;
    id_ctrl  = '0;
    stall    = 1'b0;
    alu_z    = 1'b0;
    alu_n    = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    id_valid = 1'b1;
    id_ctrl  = W_ADD;
    stall    = 1'b0;
    alu_z    = 1'b0;
    alu_n    = 1'b0;

    // Reset state, with an ADD presented in ID.
    #12;
    check("rst_alu_op", {29'd0, ex_alu_op}, 32'h2);
    check("rst_pc_sel", {30'd0, pc_sel}, 32'h0);
    check("rst_retired", {16'd0, retired}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    check("run_alu_op", {29'd0, ex_alu_op}, 32'h0);
    #2 rst = 1'b1;                     // asynchronous, mid-cycle
    #1;
    check("midrst_alu_op", {29'd0, ex_alu_op}, 32'h2);
    check("midrst_flush", {31'd0, flush_ifid}, 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    id_valid = 1'b0;
    step();
    check("postrst_wb_rw", {31'd0, wb_reg_write}, 32'h0);
    check("postrst_pc_sel", {30'd0, pc_sel}, 32'h0);
    check("postrst_retired", {16'd0, retired}, 32'h0);

    // ADD then NOPs: RegWrite reaches WB three cycles after ID.
    do_reset();
    id_valid = 1'b1;
    id_ctrl  = W_ADD;
    step();
    id_ctrl = W_NOP;
    check("add_ex_wb_rw", {31'd0, wb_reg_write}, 32'h0);
    step();
    check("add_mem_wb_rw", {31'd0, wb_reg_write}, 32'h0);
    step();
    check("add_wb_rw", {31'd0, wb_reg_write}, 32'h1);
    id_valid = 1'b0;
    step();
    check("add_retired", {16'd0, retired}, 32'h1);
    check("nop_wb_rw", {31'd0, wb_reg_write}, 32'h0);

    // SUB producing zero, then BRZ taken off the flag register.
    do_reset();
    id_valid = 1'b1;
    id_ctrl  = W_SUB;
    step();
    check("sub_alu_op", {29'd0, ex_alu_op}, 32'h5);
    alu_z   = 1'b1;
    id_ctrl = W_BRZ;
    step();
    check("brz_flag_z", {31'd0, flag_z}, 32'h1);
    check("brz_pc_sel", {30'd0, pc_sel}, 32'h1);
    check("brz_flush", {31'd0, flush_ifid}, 32'h1);
    alu_z   = 1'b0;
    id_ctrl = W_ADD;                   // killed by the flush
    step();
    check("brz_ex_bubble", {29'd0, ex_alu_op}, 32'h2);
    check("brz_after_pc_sel", {30'd0, pc_sel}, 32'h0);
    check("brz_flag_hold", {31'd0, flag_z}, 32'h1);

    // BRN with flag_n clear: no redirect, still retires.
    do_reset();
    id_valid = 1'b1;
    id_ctrl  = W_BRN;
    step();
    id_valid = 1'b0;
    check("brn_pc_sel", {30'd0, pc_sel}, 32'h0);
    check("brn_flush", {31'd0, flush_ifid}, 32'h0);
    step();
    step();
    step();
    check("brn_retired", {16'd0, retired}, 32'h1);

    // One-cycle stall with a load in EX.
    do_reset();
    id_valid = 1'b1;
    id_ctrl  = W_LD;
    step();
    check("ld_use_imm", {31'd0, ex_use_imm}, 32'h1);
    stall   = 1'b1;
    id_ctrl = W_ADD;
    step();
    check("stall_alu_op", {29'd0, ex_alu_op}, 32'h2);
    check("stall_use_imm", {31'd0, ex_use_imm}, 32'h0);
    check("stall_mem_read", {31'd0, mem_read}, 32'h1);
    stall = 1'b0;
    step();
    check("unstall_alu_op", {29'd0, ex_alu_op}, 32'h0);
    check("unstall_mem_read", {31'd0, mem_read}, 32'h0);
    check("ld_wb_m2r", {31'd0, wb_mem_to_reg}, 32'h1);
    check("ld_wb_rw", {31'd0, wb_reg_write}, 32'h1);

    // JM in MEM outranks J in EX; J is killed and never retires.
    do_reset();
    id_valid = 1'b1;
    id_ctrl  = W_JM;
    step();
    check("jm_ex_pc_sel", {30'd0, pc_sel}, 32'h0);
    id_ctrl = W_J;
    step();
    check("jm_pc_sel", {30'd0, pc_sel}, 32'h2);
    check("jm_flush", {31'd0, flush_ifid}, 32'h1);
    id_ctrl = W_ADD;
    step();
    id_valid = 1'b0;
    check("jm_ex_bubble", {29'd0, ex_alu_op}, 32'h2);
    check("jm_j_killed_pc", {30'd0, pc_sel}, 32'h0);
    step();
    step();
    check("jm_retired", {16'd0, retired}, 32'h1);

    // JM in MEM while a flag-writing SUB is in EX: the killed SUB leaves flags alone.
    do_reset();
    id_valid = 1'b1;
    id_ctrl  = W_JM;
    step();
    id_ctrl = W_SUB;
    step();
    id_valid = 1'b0;
    alu_z    = 1'b1;
    alu_n    = 1'b1;
    check("jm_sub_pc_sel", {30'd0, pc_sel}, 32'h2);
    step();
    alu_z = 1'b0;
    alu_n = 1'b0;
    check("jm_sub_flag_z", {31'd0, flag_z}, 32'h0);
    check("jm_sub_flag_n", {31'd0, flag_n}, 32'h0);
    check("jm_sub_mem_wr", {31'd0, mem_write}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
